booth_seq_mult: RTL

Parametrised, iterative radix-4 Booth multiplier with signed/unsigned operand mode and valid/ready handshakes on both sides. It is the area-reduced, multi-cycle successor to the team's 16x16 combinational Booth/Wallace multiplier. It retires one Booth digit per clock instead of building the full partial-product tree. It sits between an operand-producing stage and a result consumer, and either side may stall.

---
 rtl/booth_pkg.sv | 25 ++
 rtl/booth_r4_encoder.sv | 46 ++++
 rtl/booth_seq_mult.sv | 128 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package booth_pkg;

  // Recoded radix-4 Booth digit for one 3-bit multiplier window.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // Control states of the sequential multiplier.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } booth_state_e;

  // Number of radix-4 digits retired for a WIDTH-bit operand extended by two bits.
  function automatic int unsigned digit_count(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: turns one multiplier window into a signed partial-product term.
module booth_r4_encoder
  import booth_pkg::*;
#(
  parameter int unsigned TW = 34
) (
  input  logic [2:0]    window,
  input  logic [TW-1:0] mcand,
  output logic [TW-1:0] term_c,
  output logic          carry_c
);

  booth_digit_e digit;
  logic [TW-1:0] mag;

  // Map {b[2k+1], b[2k], b[2k-1]} onto a digit in {-2,-1,0,+1,+2}.
  always_comb begin
    digit = ZERO;
    case (window)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

  // Select magnitude, then invert for negative digits; the +1 comes through carry_c.
  always_comb begin
    mag     = mcand;
    term_c  = '0;
    carry_c = 1'b0;
    if (digit == POS2 || digit == NEG2) begin
      mag = {mcand[TW-2:0], 1'b0};
    end
    case (digit)
      POS1, POS2: term_c = mag;
      NEG1, NEG2: begin
        term_c  = ~mag;
        carry_c = 1'b1;
      end
      default: term_c = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned N   = digit_count(WIDTH);
  localparam int unsigned CW  = $clog2(N);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned AW  = 2 * WIDTH + 2;
  localparam int unsigned MPW = WIDTH + 3;

  booth_state_e   state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [AW-1:0]  mcand_q, mcand_d;
  logic [MPW-1:0] mplier_q, mplier_d;
  logic           mode_q, mode_d;
  logic [PW-1:0]  p_q, p_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic [AW-1:0]  term;
  logic           carry;
  logic           a_ext, b_ext, fill;

  // Partial-product term for the current window; the multiplicand register is pre-shifted by 2k.
  booth_r4_encoder #(
    .TW(AW)
  ) u_enc (
    .window (mplier_q[2:0]),
    .mcand  (mcand_q),
    .term_c (term),
    .carry_c(carry)
  );

  assign a_ext = signed_mode & a[WIDTH-1];
  assign b_ext = signed_mode & b[WIDTH-1];
  assign fill  = mode_q & mplier_q[MPW-1];

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mode_d   = mode_q;
    p_d      = p_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mcand_d  = {{(WIDTH + 2){a_ext}}, a};
          mplier_d = {b_ext, b_ext, b, 1'b0};
          mode_d   = signed_mode;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_q + term + AW'(carry);
        mcand_d  = {mcand_q[AW-3:0], 2'b00};
        mplier_d = {fill, fill, mplier_q[MPW-1:2]};
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          p_d     = acc_d[PW-1:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      mode_q      <= 1'b0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      mode_q      <= mode_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Ready flop sits preset during reset so acceptance opens in the first cycle after rst drops.
  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule
